ps2_keyboard_rx: RTL

//  Receives PS/2 keyboard frames and delivers make codes to the game logic as
//  kb_data / kb_data_avail, the keyboard inputs consumed by the Graphics and

---
 rtl/ps2_keyboard_rx_if.sv | 21 ++
 rtl/ps2_keyboard_rx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - keyboard code delivery bus from the PS/2 receiver
interface ps2_keyboard_rx_if;
    logic [7:0] kb_data;
    logic       kb_data_avail;
    logic       kb_extended;
    logic       kb_error;

    modport master (
        output kb_data,
        output kb_data_avail,
        output kb_extended,
        output kb_error
    );

    modport slave (
        input kb_data,
        input kb_data_avail,
        input kb_extended,
        input kb_error
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver delivering make codes (E0 stripped, F0 releases dropped)
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_keyboard_rx_if.master kb
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filt_fall;

    state_t        state, state_next;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;
    logic [TW-1:0] idle_cnt;
    logic          ext_pend, brk_pend;
    logic          frame_done, frame_ok, timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign filt_fall = filt_clk & ~clk_s2 & (filt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (filt_fall && !dat_s2) state_next = RECV;
            end
            RECV: begin
                if (filt_fall) begin
                    if (bit_cnt == 4'd9) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end
                end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // shift[7:0] is the data byte and shift[8] the parity bit once nine bits are in.
    assign frame_ok = frame_done & dat_s2 & (^shift);

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            idle_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else if (filt_fall) begin
            idle_cnt <= '0;
            if (bit_cnt != 4'd9) begin
                shift   <= {dat_s2, shift[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kb.kb_data       <= '0;
            kb.kb_extended   <= 1'b0;
            kb.kb_data_avail <= 1'b0;
            kb.kb_error      <= 1'b0;
            ext_pend         <= 1'b0;
            brk_pend         <= 1'b0;
        end else begin
            kb.kb_data_avail <= 1'b0;
            kb.kb_error      <= 1'b0;
            if (timeout) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (frame_done && !frame_ok) begin
                kb.kb_error <= 1'b1;
                ext_pend    <= 1'b0;
                brk_pend    <= 1'b0;
            end else if (frame_ok) begin
                if (shift[7:0] == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shift[7:0] == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    if (!brk_pend) begin
                        kb.kb_data       <= shift[7:0];
                        kb.kb_extended   <= ext_pend;
                        kb.kb_data_avail <= 1'b1;
                    end
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end
endmodule
